pc_fetch_seq: RTL and testbench

//   Owns the architectural PC register and sequences instruction fetch around the next-PC unit.

---
 rtl/pc_fetch_seq.sv | 96 +++++++++
 tb/tb_pc_fetch_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - PC register and instruction fetch sequencer between imem and decode/next-PC.
// Optional macro PC_ALIGN_CHECK_EN: misaligned npc_in on accept faults instead of being truncated.
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  input  logic        ir_ready,
  input  logic        stall,
  output logic [31:0] pc,
  input  logic [31:0] npc_in,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       accept;
  logic       misaligned;

  assign accept    = ir_ready & ~stall;
  assign imem_addr = pc;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |npc_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          cnt      <= '0;
          state    <= FETCH;
        end
        FETCH: begin
          // An ack arriving on the last allowed cycle still completes the fetch.
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            cnt      <= '0;
            state    <= HOLD;
          end else if (cnt == CNT_LAST) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (accept) begin
            ir_valid <= 1'b0;
            if (misaligned) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              pc       <= npc_in & ~32'd3;
              imem_req <= 1'b1;
              cnt      <= '0;
              state    <= FETCH;
            end
          end
        end
        ERR: begin
          imem_req  <= 1'b0;
          ir_valid  <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - directed scoreboard bench for pc_fetch_seq.
module tb_pc_fetch_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir;
  logic        ir_ready;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] npc_in;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  pc_fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir(ir),
    .ir_ready(ir_ready), .stall(stall), .pc(pc), .npc_in(npc_in), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("ir_valid_set", {31'd0, ir_valid}, 32'd1);
    check("ir_word", ir, exp_q.pop_front());
    check("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_accept(input logic [31:0] npc);
    npc_in   = npc;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0; stall = 1'b0; npc_in = '0;
    tick();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("fetch_req_after_rst", {31'd0, imem_req}, 32'd1);

    // Asynchronous reset in the middle of a fetch.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_pc", pc, 32'h0000_3000);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("idle_ack_ir", ir, 32'h0);
    check("idle_ack_valid", {31'd0, ir_valid}, 32'd0);
    tick();
    check("req_2nd_edge", {31'd0, imem_req}, 32'd1);
    check("addr_2nd_edge", imem_addr, 32'h0000_3000);

    // Sequential fetch.
    do_fetch(32'h0000_3000, 32'h2008_0005);
    do_accept(32'h0000_3004);
    check("seq_pc", pc, 32'h0000_3004);
    check("seq_valid_clr", {31'd0, ir_valid}, 32'd0);
    check("seq_req", {31'd0, imem_req}, 32'd1);

    // Stall in HOLD, with a stray ack that must not touch ir.
    do_fetch(32'h0000_3004, 32'h8C01_0004);
    stall = 1'b1; ir_ready = 1'b1; npc_in = 32'h0000_3008;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", pc, 32'h0000_3004);
      check("stall_valid", {31'd0, ir_valid}, 32'd1);
      check("stall_ir", ir, 32'h8C01_0004);
    end
    imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0;
    tick();
    ir_ready = 1'b0;
    check("unstall_pc", pc, 32'h0000_3008);

    // Ack on the 16th waiting cycle still succeeds.
    for (int i = 0; i < 15; i++) tick();
    check("late_no_err", {31'd0, fetch_err}, 32'd0);
    do_fetch(32'h0000_3008, 32'h0000_000C);
    check("late_ack_err", {31'd0, fetch_err}, 32'd0);
    do_accept(32'h0000_300C);

    // Timeout: 16 cycles without ack.
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_err", {31'd0, fetch_err}, 32'd0);
    check("to_pre_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; ir_ready = 1'b1; npc_in = 32'h0000_4000;
    tick(); tick();
    imem_ack = 1'b0; ir_ready = 1'b0;
    check("err_pc_frozen", pc, 32'h0000_300C);
    check("err_valid", {31'd0, ir_valid}, 32'd0);
    check("err_sticky", {31'd0, fetch_err}, 32'd1);

    // Redirect, wrap, then misaligned target.
    do_reset();
    check("rec_err", {31'd0, fetch_err}, 32'd0);
    do_fetch(32'h0000_3000, 32'h1000_0003);
    do_accept(32'h0000_3010);
    check("redir_addr", imem_addr, 32'h0000_3010);
    do_fetch(32'h0000_3010, 32'h0800_0000);
    do_accept(32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0000);
    do_accept(32'h0000_0000);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    do_fetch(32'h0000_0000, 32'h0800_0C04);
    do_accept(32'h0000_3010);
    do_fetch(32'h0000_3010, 32'h0000_0008);
    do_accept(32'h0000_3011);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_err", {31'd0, fetch_err}, 32'd1);
    check("misalign_pc", pc, 32'h0000_3010);
    check("misalign_req", {31'd0, imem_req}, 32'd0);
`else
    check("misalign_err", {31'd0, fetch_err}, 32'd0);
    check("misalign_addr", imem_addr, 32'h0000_3010);
    check("misalign_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
